// File: rtl/mlp_seq.sv
`default_nettype none
// ============================================================================
// Module   : mlp_seq
// Function : Two-layer fixed-point MLP (in -> hidden -> out) evaluated one
//            multiply-accumulate per cycle with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_seq #(
    parameter int NBits    = 16,
    parameter int FracBits = 8,
    parameter int DIn      = 6,
    parameter int DHid     = 16,
    parameter int DOut     = 3,
    parameter int ReluEn   = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DIn*NBits-1:0]          din_i,
    input  logic [DIn*DHid*NBits-1:0]     w1_i,
    input  logic [DHid*NBits-1:0]         b1_i,
    input  logic [DHid*DOut*NBits-1:0]    w2_i,
    input  logic [DOut*NBits-1:0]         b2_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DOut*NBits-1:0]         dout_o,
    output logic                          sat_o
);

    localparam int c_MAXK  = (DIn > DHid) ? DIn : DHid;
    localparam int c_ACC_W = 2*NBits + $clog2(c_MAXK + 1) + 1;
    localparam int c_CW    = $clog2(DIn + DHid + DOut + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_L1   = 2'd1;
    localparam logic [1:0] c_L2   = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W-NBits+1){1'b0}}, {(NBits-1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W-NBits+1){1'b1}}, {(NBits-1){1'b0}}};

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [c_CW-1:0]           r_k;
    logic [c_CW-1:0]           r_j;
    logic signed [c_ACC_W-1:0] r_acc;
    logic                      r_sat;

    logic signed [NBits-1:0]   r_din  [DIn];
    logic signed [NBits-1:0]   r_w1   [DIn][DHid];
    logic signed [NBits-1:0]   r_b1   [DHid];
    logic signed [NBits-1:0]   r_w2   [DHid][DOut];
    logic signed [NBits-1:0]   r_b2   [DOut];
    logic signed [NBits-1:0]   r_hid  [DHid];
    logic signed [NBits-1:0]   r_dout [DOut];

    logic signed [NBits-1:0]   w_a;
    logic signed [NBits-1:0]   w_b;
    logic signed [NBits-1:0]   w_bias;
    logic                      w_k_last;
    logic                      w_j_last;
    logic signed [2*NBits-1:0] w_prod;
    logic signed [c_ACC_W-1:0] w_bias_ext;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic signed [c_ACC_W-1:0] w_shift;
    logic signed [NBits-1:0]   w_res;
    logic signed [NBits-1:0]   w_act;
    logic                      w_clamp;

    // Operand selection: term k of neuron j in the active layer
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_bias = '0;
        if (r_state == c_L1) begin
            for (int k = 0; k < DIn; k++)
                if (r_k == c_CW'(k)) w_a = r_din[k];
            for (int k = 0; k < DIn; k++)
                for (int j = 0; j < DHid; j++)
                    if (r_k == c_CW'(k) && r_j == c_CW'(j)) w_b = r_w1[k][j];
            for (int j = 0; j < DHid; j++)
                if (r_j == c_CW'(j)) w_bias = r_b1[j];
        end else begin
            for (int k = 0; k < DHid; k++)
                if (r_k == c_CW'(k)) w_a = r_hid[k];
            for (int k = 0; k < DHid; k++)
                for (int j = 0; j < DOut; j++)
                    if (r_k == c_CW'(k) && r_j == c_CW'(j)) w_b = r_w2[k][j];
            for (int j = 0; j < DOut; j++)
                if (r_j == c_CW'(j)) w_bias = r_b2[j];
        end
    end

    assign w_k_last = (r_state == c_L1) ? (r_k == c_CW'(DIn - 1))  : (r_k == c_CW'(DHid - 1));
    assign w_j_last = (r_state == c_L1) ? (r_j == c_CW'(DHid - 1)) : (r_j == c_CW'(DOut - 1));

    assign w_prod     = {{NBits{w_a[NBits-1]}}, w_a} * {{NBits{w_b[NBits-1]}}, w_b};
    assign w_bias_ext = {{(c_ACC_W-NBits){w_bias[NBits-1]}}, w_bias} << FracBits;
    // Bias preload and first product land in the same cycle
    assign w_acc_next = ((r_k == '0) ? w_bias_ext : r_acc)
                      + {{(c_ACC_W-2*NBits){w_prod[2*NBits-1]}}, w_prod};
    assign w_shift    = w_acc_next >>> FracBits;

    always_comb begin
        w_clamp = 1'b0;
        w_res   = w_shift[NBits-1:0];
        if (w_shift > c_SAT_MAX) begin
            w_res   = c_SAT_MAX[NBits-1:0];
            w_clamp = 1'b1;
        end else if (w_shift < c_SAT_MIN) begin
            w_res   = c_SAT_MIN[NBits-1:0];
            w_clamp = 1'b1;
        end
    end

    // ReLU follows saturation so it never contributes to the sat flag
    assign w_act = (ReluEn != 0 && r_state == c_L1 && w_res[NBits-1]) ? '0 : w_res;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (in_valid_i)           w_state_next = c_L1;
            c_L1:    if (w_k_last && w_j_last) w_state_next = c_L2;
            c_L2:    if (w_k_last && w_j_last) w_state_next = c_DONE;
            c_DONE:  if (out_ready_i)          w_state_next = c_IDLE;
            default:                           w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_k   <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_sat <= 1'b0;
            for (int i = 0; i < DIn; i++) r_din[i] <= '0;
            for (int i = 0; i < DIn; i++)
                for (int j = 0; j < DHid; j++) r_w1[i][j] <= '0;
            for (int i = 0; i < DHid; i++) r_b1[i] <= '0;
            for (int i = 0; i < DHid; i++) r_hid[i] <= '0;
            for (int i = 0; i < DHid; i++)
                for (int j = 0; j < DOut; j++) r_w2[i][j] <= '0;
            for (int i = 0; i < DOut; i++) r_b2[i] <= '0;
            for (int i = 0; i < DOut; i++) r_dout[i] <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid_i) begin
                        r_k   <= '0;
                        r_j   <= '0;
                        r_acc <= '0;
                        r_sat <= 1'b0;
                        for (int i = 0; i < DIn; i++)
                            r_din[i] <= din_i[i*NBits +: NBits];
                        for (int i = 0; i < DIn; i++)
                            for (int j = 0; j < DHid; j++)
                                r_w1[i][j] <= w1_i[(i*DHid + j)*NBits +: NBits];
                        for (int i = 0; i < DHid; i++)
                            r_b1[i] <= b1_i[i*NBits +: NBits];
                        for (int i = 0; i < DHid; i++)
                            for (int j = 0; j < DOut; j++)
                                r_w2[i][j] <= w2_i[(i*DOut + j)*NBits +: NBits];
                        for (int i = 0; i < DOut; i++)
                            r_b2[i] <= b2_i[i*NBits +: NBits];
                    end
                end
                c_L1, c_L2: begin
                    if (w_k_last) begin
                        r_k   <= '0;
                        r_acc <= '0;
                        r_j   <= w_j_last ? '0 : r_j + c_CW'(1);
                        r_sat <= r_sat | w_clamp;
                        if (r_state == c_L1) begin
                            for (int j = 0; j < DHid; j++)
                                if (r_j == c_CW'(j)) r_hid[j] <= w_act;
                        end else begin
                            for (int j = 0; j < DOut; j++)
                                if (r_j == c_CW'(j)) r_dout[j] <= w_act;
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_k   <= r_k + c_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (r_state == c_IDLE);
    assign out_valid_o = (r_state == c_DONE);
    assign sat_o       = r_sat;

    for (genvar g = 0; g < DOut; g++) begin : g_dout
        assign dout_o[g*NBits +: NBits] = r_dout[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_mlp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_seq
// Function : Self-checking bench for mlp_seq (ReLU and identity variants).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_seq;

    localparam int NB   = 16;
    localparam int DIN  = 6;
    localparam int DHID = 16;
    localparam int DOUT = 3;
    localparam int LAT  = DIN*DHID + DHID*DOUT;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic ir_a, ir_b, ov_a, ov_b, sat_a, sat_b;
    logic [DOUT*NB-1:0] dout_a, dout_b;

    logic signed [NB-1:0] din_a [DIN];
    logic signed [NB-1:0] w1_a  [DIN][DHID];
    logic signed [NB-1:0] b1_a  [DHID];
    logic signed [NB-1:0] w2_a  [DHID][DOUT];
    logic signed [NB-1:0] b2_a  [DOUT];

    logic [DIN*NB-1:0]       din_f;
    logic [DIN*DHID*NB-1:0]  w1_f;
    logic [DHID*NB-1:0]      b1_f;
    logic [DHID*DOUT*NB-1:0] w2_f;
    logic [DOUT*NB-1:0]      b2_f;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        din_f = '0; w1_f = '0; b1_f = '0; w2_f = '0; b2_f = '0;
        for (int k = 0; k < DIN; k++) din_f[k*NB +: NB] = din_a[k];
        for (int k = 0; k < DIN; k++)
            for (int j = 0; j < DHID; j++) w1_f[(k*DHID + j)*NB +: NB] = w1_a[k][j];
        for (int j = 0; j < DHID; j++) b1_f[j*NB +: NB] = b1_a[j];
        for (int k = 0; k < DHID; k++)
            for (int j = 0; j < DOUT; j++) w2_f[(k*DOUT + j)*NB +: NB] = w2_a[k][j];
        for (int j = 0; j < DOUT; j++) b2_f[j*NB +: NB] = b2_a[j];
    end

    mlp_seq #(.ReluEn(1)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir_a),
        .din_i(din_f), .w1_i(w1_f), .b1_i(b1_f), .w2_i(w2_f), .b2_i(b2_f),
        .out_valid_o(ov_a), .out_ready_i(out_ready), .dout_o(dout_a), .sat_o(sat_a)
    );

    mlp_seq #(.ReluEn(0)) dut_nr (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir_b),
        .din_i(din_f), .w1_i(w1_f), .b1_i(b1_f), .w2_i(w2_f), .b2_i(b2_f),
        .out_valid_o(ov_b), .out_ready_i(out_ready), .dout_o(dout_b), .sat_o(sat_b)
    );

    typedef struct {
        int          kind;    // 0 bias passthrough, 1 single-path ReLU, 2 saturation
        logic [15:0] din0;
        logic [47:0] exp_a;   // {d2,d1,d0} with ReLU
        bit          exp_sat;
        logic [47:0] exp_b;   // {d2,d1,d0} without ReLU
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rq();
        return 16'($urandom_range(0, 2047)) - 16'd1024;
    endfunction

    task automatic clear_all();
        for (int k = 0; k < DIN; k++) din_a[k] = '0;
        for (int k = 0; k < DIN; k++) for (int j = 0; j < DHID; j++) w1_a[k][j] = '0;
        for (int j = 0; j < DHID; j++) b1_a[j] = '0;
        for (int k = 0; k < DHID; k++) for (int j = 0; j < DOUT; j++) w2_a[k][j] = '0;
        for (int j = 0; j < DOUT; j++) b2_a[j] = '0;
    endtask

    task automatic setup(input int kind, input logic [15:0] d0);
        clear_all();
        case (kind)
            0: begin
                b2_a[0] = 16'h0100; b2_a[1] = 16'hFF00; b2_a[2] = 16'h7FFF;
            end
            1: begin
                din_a[0] = d0; w1_a[0][0] = 16'h0100; w2_a[0][0] = 16'h0100;
            end
            default: begin
                for (int k = 0; k < DIN; k++) din_a[k] = 16'h7FFF;
                for (int k = 0; k < DIN; k++) for (int j = 0; j < DHID; j++) w1_a[k][j] = 16'h7FFF;
                for (int j = 0; j < DHID; j++) b1_a[j] = 16'h7FFF;
                w2_a[0][0] = 16'h0100;
            end
        endcase
    endtask

    task automatic scramble();
        for (int k = 0; k < DIN; k++) din_a[k] = rq();
        for (int k = 0; k < DIN; k++) for (int j = 0; j < DHID; j++) w1_a[k][j] = rq();
    endtask

    // Real-number semantics: value = raw / 256, results floored and clamped to int16
    function automatic longint clamp16(input longint v, inout bit s);
        if (v > 32767)  begin s = 1'b1; return 32767;  end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return v;
    endfunction

    task automatic model(input bit relu, output logic [47:0] d, output bit s);
        longint hid [DHID];
        longint acc;
        s = 1'b0;
        d = '0;
        for (int j = 0; j < DHID; j++) begin
            acc = longint'(b1_a[j]) * 256;
            for (int k = 0; k < DIN; k++) acc += longint'(din_a[k]) * longint'(w1_a[k][j]);
            hid[j] = clamp16(acc >>> 8, s);
            if (relu && hid[j] < 0) hid[j] = 0;
        end
        for (int j = 0; j < DOUT; j++) begin
            acc = longint'(b2_a[j]) * 256;
            for (int k = 0; k < DHID; k++) acc += hid[k] * longint'(w2_a[k][j]);
            d[j*16 +: 16] = 16'(clamp16(acc >>> 8, s));
        end
    endtask

    // Accept one vector and count negedges until out_valid_o appears
    task automatic run_one(input bit mutate, output int lat);
        int w = 0;
        while (!ir_a && w < 400) begin @(negedge clk); w++; end
        check("in_ready_wait", 64'(ir_a), 64'd1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!ov_a && lat < 400) begin
            if (mutate) scramble();
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t tbl [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          seen;
        logic [47:0] ed_a, ed_b;
        bit          es_a, es_b;

        tbl[0] = '{0, 16'h0000, {16'h7FFF, 16'hFF00, 16'h0100}, 1'b0, {16'h7FFF, 16'hFF00, 16'h0100}};
        tbl[1] = '{1, 16'hFF00, 48'h0,                           1'b0, {32'h0, 16'hFF00}};
        tbl[2] = '{1, 16'h0200, {32'h0, 16'h0200},               1'b0, {32'h0, 16'h0200}};
        tbl[3] = '{2, 16'h0000, {32'h0, 16'h7FFF},               1'b1, {32'h0, 16'h7FFF}};
        tbl[4] = '{0, 16'h0000, {16'h7FFF, 16'hFF00, 16'h0100}, 1'b0, {16'h7FFF, 16'hFF00, 16'h0100}};

        clear_all();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready",  64'(ir_a),  64'd1);
        check("reset_out_valid", 64'(ov_a),  64'd0);
        check("reset_dout",      64'(dout_a), 64'd0);
        check("reset_sat",       64'(sat_a), 64'd0);

        for (int i = 0; i < 5; i++) begin
            setup(tbl[i].kind, tbl[i].din0);
            run_one(1'b0, lat);
            check($sformatf("vec%0d_latency", i),   64'(lat),    64'(LAT));
            check($sformatf("vec%0d_out_valid", i), 64'(ov_b),   64'd1);
            check($sformatf("vec%0d_dout", i),      64'(dout_a), 64'(tbl[i].exp_a));
            check($sformatf("vec%0d_sat", i),       64'(sat_a),  64'(tbl[i].exp_sat));
            check($sformatf("vec%0d_dout_norelu", i), 64'(dout_b), 64'(tbl[i].exp_b));
            check($sformatf("vec%0d_sat_norelu", i),  64'(sat_b),  64'(tbl[i].exp_sat));
            @(negedge clk);
            check($sformatf("vec%0d_valid_drop", i), 64'(ov_a), 64'd0);
            check($sformatf("vec%0d_ready_back", i), 64'(ir_a), 64'd1);
        end

        // Backpressure with an ignored input pulse during DONE
        out_ready = 1'b0;
        setup(0, 16'h0);
        run_one(1'b0, lat);
        check("bp_latency", 64'(lat), 64'(LAT));
        for (int c = 0; c < 20; c++) begin
            check("bp_dout",      64'(dout_a), 64'(tbl[0].exp_a));
            check("bp_sat",       64'(sat_a),  64'd0);
            check("bp_out_valid", 64'(ov_a),   64'd1);
            check("bp_in_ready",  64'(ir_a),   64'd0);
            in_valid = (c == 5);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(ov_a), 64'd0);
        check("bp_release_ready", 64'(ir_a), 64'd1);
        repeat (3) @(negedge clk);
        check("bp_pulse_not_queued", 64'(ir_a), 64'd1);

        // Reset in the middle of layer 1
        setup(0, 16'h0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_in_ready",  64'(ir_a),   64'd1);
        check("mrst_out_valid", 64'(ov_a),   64'd0);
        check("mrst_dout",      64'(dout_a), 64'd0);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (ov_a) seen++;
        end
        check("mrst_no_stray", 64'(seen), 64'd0);
        run_one(1'b0, lat);
        check("mrst_latency", 64'(lat),    64'(LAT));
        check("mrst_dout2",   64'(dout_a), 64'(tbl[0].exp_a));

        // Back-to-back random inferences, inputs scrambled while busy
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < DIN; k++) din_a[k] = rq();
            for (int k = 0; k < DIN; k++) for (int j = 0; j < DHID; j++) w1_a[k][j] = rq();
            for (int j = 0; j < DHID; j++) b1_a[j] = rq();
            for (int k = 0; k < DHID; k++) for (int j = 0; j < DOUT; j++) w2_a[k][j] = rq();
            for (int j = 0; j < DOUT; j++) b2_a[j] = rq();
            model(1'b1, ed_a, es_a);
            model(1'b0, ed_b, es_b);
            run_one(1'b1, lat);
            check($sformatf("rnd%0d_latency", n),      64'(lat),    64'(LAT));
            check($sformatf("rnd%0d_ready_done", n),   64'(ir_a),   64'd0);
            check($sformatf("rnd%0d_ready_done_nr", n), 64'(ir_b),  64'd0);
            check($sformatf("rnd%0d_dout", n),         64'(dout_a), 64'(ed_a));
            check($sformatf("rnd%0d_sat", n),          64'(sat_a),  64'(es_a));
            check($sformatf("rnd%0d_dout_norelu", n),  64'(dout_b), 64'(ed_b));
            check($sformatf("rnd%0d_sat_norelu", n),   64'(sat_b),  64'(es_b));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mlp_seq.md
Name: mlp_seq

Overview:
- Time-multiplexed, parametrised two-layer MLP inference engine (input -> hidden -> output) in signed fixed point.
- Uses one shared MAC instead of fully parallel dense layers, so area scales with the widest layer, not with layer size.
- Adds a valid/ready handshake on input and output, optional ReLU on the hidden layer, and a saturation flag.
- Sits between the sensor feature front-end and the classifier decision logic.

Parameters:
- NBits, 16, data/weight/bias width (signed two's complement).
- FracBits, 8, fractional bits of the Q format shared by all operands.
- DIn, 6, input vector length.
- DHid, 16, hidden layer width.
- DOut, 3, output vector length.
- ReluEn, 1, 1 = apply ReLU to hidden activations; 0 = identity.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; synchronous, active-high.
- in_valid_i, in, 1, input vector and weights valid.
- in_ready_o, out, 1, engine idle and able to accept.
- din_i, in, NBits x [DIn], input features.
- w1_i, in, NBits x [DIn][DHid], layer-1 weights.
- b1_i, in, NBits x [DHid], layer-1 biases.
- w2_i, in, NBits x [DHid][DOut], layer-2 weights.
- b2_i, in, NBits x [DOut], layer-2 biases.
- out_valid_o, out, 1, dout_o holds a result.
- out_ready_i, in, 1, consumer accepts the result.
- dout_o, out, NBits x [DOut], output vector.
- sat_o, out, 1, at least one saturation occurred in this inference; qualified by out_valid_o.

Behaviour:
- **Reset:**
  - state = IDLE, in_ready_o = 1, out_valid_o = 0, dout_o = 0, sat_o = 0.
  - Accumulator, counters and hidden buffer are cleared.
  - Reset in any state aborts the inference; no result is produced.
- **States:**
  - IDLE -> L1 on in_valid_i & in_ready_o. On that edge din_i, w1_i, b1_i, w2_i, b2_i are registered; later changes on these ports are ignored.
  - L1 -> L2 after the last hidden neuron is written back.
  - L2 -> DONE after the last output neuron is written back.
  - DONE -> IDLE on out_ready_i.
- **Handshake:**
  - in_ready_o = (state == IDLE).
  - out_valid_o = (state == DONE).
  - dout_o and sat_o are stable while out_valid_o = 1 & out_ready_i = 0.
  - No accept is possible in the DONE cycle, so there is at least one idle cycle between inferences.
- **MAC schedule:**
  - One multiply-accumulate per cycle.
  - Neuron j is processed in input order k = 0..K-1, where K = DIn for L1 and DHid for L2.
  - The accumulator is preloaded with sign-extended bias << FracBits on the neuron's first cycle, in the same cycle as the first product.
  - Writeback happens at the end of the last term.
  - L1 takes DIn*DHid cycles; L2 takes DHid*DOut cycles.
  - out_valid_o rises exactly DIn*DHid + DHid*DOut cycles after the accept edge (144 with defaults).
- **Arithmetic:**
  - Product is a signed 2*NBits value.
  - Accumulator width is 2*NBits + clog2(max(DIn,DHid)+1) + 1; it never overflows internally.
  - Writeback: arithmetic shift right by FracBits (floor), then saturate to [-2^(NBits-1), 2^(NBits-1)-1].
  - Any clamp sets the internal sat flag, which is cleared on accept.
  - Hidden layer: if ReluEn, negative results are stored as 0. ReLU is applied after saturation and does not set sat.
  - Output layer: no activation.
- **Boundary conditions:**
  - in_valid_i while busy: ignored, not queued.
  - out_ready_i asserted outside DONE: no effect.
  - Counters wrap to 0 at layer boundaries. DIn, DHid and DOut must each be >= 1.

Test Plan:
- Bias passthrough (defaults, Q8.8): all weights 0, b2 = {0x0100, 0xFF00, 0x7FFF}, out_ready_i = 1 -> dout = {0x0100, 0xFF00, 0x7FFF}, sat_o = 0, out_valid_o exactly 144 cycles after accept, high for 1 cycle.
- ReLU: w1[0][0] = 0x0100, w2[0][0] = 0x0100, all else 0.
  - din[0] = 0xFF00 -> dout[0] = 0x0000.
  - din[0] = 0x0200 -> dout[0] = 0x0200.
  - Same two vectors with ReluEn = 0 -> dout[0] = 0xFF00 and 0x0200.
- Saturation: din, w1 and b1 all 0x7FFF; w2[0][0] = 0x0100, all other w2 and b2 = 0 -> dout[0] = 0x7FFF, sat_o = 1. Next inference with the bias-passthrough vectors -> sat_o = 0.
- Backpressure: hold out_ready_i = 0 for 20 cycles after out_valid_o rises -> dout_o/sat_o stable, in_ready_o = 0, and a pulsed in_valid_i is ignored. Release -> out_valid_o falls, in_ready_o = 1 next cycle.
- Mid-run reset: assert rst_i for 1 cycle at cycle 50 of L1 -> next cycle in_ready_o = 1, out_valid_o = 0, dout_o = 0, and no stray result follows. A new bias-passthrough inference then completes correctly in 144 cycles.
- Back-to-back with input mutation:
  - Issue 3 inferences with random Q8.8 vectors, changing din_i/w1_i every cycle while busy.
  - Results must match a golden model using the values captured at each accept.
  - in_ready_o must be 0 on every DONE cycle.
